// File: rtl/sema_hub_pkg.sv
// Shared sizing, request word layout and lock-table entry types for the semaphore hub.
package sema_hub_pkg;

  localparam int NUM_ON_CHIP_IP = 2;
  localparam int NUM_THREADS    = 2;
  localparam int NUM_SEMA       = 16;
  localparam int SEMA_WIDTH     = 8;
  localparam int NUM_REQ        = NUM_ON_CHIP_IP * NUM_THREADS;
  localparam int SIDW           = $clog2(NUM_SEMA);
  localparam int REQW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [SEMA_WIDTH-1:0]            sema_t;
  typedef sema_t [NUM_THREADS-1:0]          semathread_t;
  typedef semathread_t [NUM_ON_CHIP_IP-1:0] semathreadip_t;

  typedef enum logic {
    SEMA_ACQ = 1'b0,
    SEMA_REL = 1'b1
  } sema_op_e;

  typedef logic [REQW-1:0] owner_t;

  typedef struct packed {
    logic   lock;
    owner_t owner;
  } sema_entry_t;

  // Only matters when NUM_SEMA is not a power of two.
  function automatic logic sema_id_ok(logic [SIDW-1:0] id);
    return 32'(id) < NUM_SEMA;
  endfunction

endpackage

// File: rtl/sema_hub_if.sv
// Requester-side bundle of the semaphore hub: requests, completions, flush and status.
interface sema_hub_if;
  import sema_hub_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  semathreadip_t             req_word;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_ok;
  logic [NUM_ON_CHIP_IP-1:0] ip_flush;
  logic [NUM_SEMA-1:0]       sema_locked;
  logic                      misuse_err;

  modport master (
    output req_valid, req_word, ip_flush,
    input  req_ack, req_ok, sema_locked, misuse_err
  );

  modport slave (
    input  req_valid, req_word, ip_flush,
    output req_ack, req_ok, sema_locked, misuse_err
  );

endinterface

// File: rtl/sema_hub_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module sema_rr_arb #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o,
  output logic         any_o
);

  logic [W-1:0] cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'((32'(ptr_i) + 32'(i)) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/sema_hub.sv
// Semaphore hub: one try-lock acquire/release accepted per cycle, owner tracking,
// per-IP force release and sticky misuse flag.
module sema_hub
  import sema_hub_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  sema_hub_if.slave bus
);

  sema_entry_t        sema_tbl_q [NUM_SEMA];
  sema_entry_t        sema_tbl_d [NUM_SEMA];
  owner_t             rr_q, rr_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] ok_q, ok_d;
  logic               misuse_q, misuse_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] flush_req;
  owner_t             gnt_idx;
  logic               gnt_any;
  sema_t              words [NUM_REQ];
  sema_t              g_word;
  logic [SIDW-1:0]    g_id;
  sema_op_e           g_op;
  logic               unused_word_bits;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign flush_req[r] = bus.ip_flush[r / NUM_THREADS];
    assign words[r]     = bus.req_word[r / NUM_THREADS][r % NUM_THREADS];
  end

  // A requester still showing its ack this cycle is not re-arbitrated.
  assign elig = bus.req_valid & ~ack_q;

  sema_rr_arb #(.N(NUM_REQ), .W(REQW)) u_arb (
    .req_i     (elig),
    .ptr_i     (rr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  assign g_word           = words[gnt_idx];
  assign g_id             = g_word[SIDW-1:0];
  assign g_op             = sema_op_e'(g_word[SEMA_WIDTH-1]);
  assign unused_word_bits = ^g_word[SEMA_WIDTH-2:SIDW];

  always_comb begin
    for (int s = 0; s < NUM_SEMA; s++) begin
      sema_tbl_d[s] = sema_tbl_q[s];
      if (sema_tbl_q[s].lock && flush_req[sema_tbl_q[s].owner]) begin
        sema_tbl_d[s] = '0;
      end
    end
    ack_d    = gnt;
    ok_d     = '0;
    misuse_d = misuse_q;
    rr_d     = rr_q;

    // The granted op is evaluated against the post-flush table.
    if (gnt_any) begin
      rr_d = (gnt_idx == owner_t'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (!flush_req[gnt_idx]) begin
        if (!sema_id_ok(g_id)) begin
          misuse_d = 1'b1;
        end else if (g_op == SEMA_ACQ) begin
          if (!sema_tbl_d[g_id].lock) begin
            sema_tbl_d[g_id].lock  = 1'b1;
            sema_tbl_d[g_id].owner = gnt_idx;
            ok_d[gnt_idx]          = 1'b1;
          end
        end else if (sema_tbl_d[g_id].lock && sema_tbl_d[g_id].owner == gnt_idx) begin
          sema_tbl_d[g_id] = '0;
          ok_d[gnt_idx]    = 1'b1;
        end else begin
          misuse_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NUM_SEMA; s++) begin
        sema_tbl_q[s] <= '0;
      end
      rr_q     <= '0;
      ack_q    <= '0;
      ok_q     <= '0;
      misuse_q <= 1'b0;
    end else begin
      sema_tbl_q <= sema_tbl_d;
      rr_q       <= rr_d;
      ack_q      <= ack_d;
      ok_q       <= ok_d;
      misuse_q   <= misuse_d;
    end
  end

  for (genvar s = 0; s < NUM_SEMA; s++) begin : g_status
    assign bus.sema_locked[s] = sema_tbl_q[s].lock;
  end

  assign bus.req_ack    = ack_q;
  assign bus.req_ok     = ok_q;
  assign bus.misuse_err = misuse_q;

endmodule

// File: tb/tb_sema_hub.sv
// Directed scenarios plus randomized traffic against a behavioural lock-table model.
module tb_sema_hub;
  import sema_hub_pkg::*;

  logic clk = 1'b0;
  logic reset;

  sema_hub_if sif ();

  sema_hub dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit                 m_lock  [NUM_SEMA];
  int                 m_owner [NUM_SEMA];
  bit                 m_mis;
  int                 m_rr;
  logic [NUM_REQ-1:0] m_ack, m_ok;

  // stimulus state
  logic [NUM_REQ-1:0]        vld;
  logic [7:0]                wrd [NUM_REQ];
  logic [NUM_ON_CHIP_IP-1:0] fl;

  function automatic logic [7:0] mk(bit rel, int id);
    return {rel, 3'b000, 4'(id)};
  endfunction

  function automatic logic [7:0] rand_word();
    int id;
    id = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
    return {1'($urandom_range(0, 1)), 3'($urandom), 4'(id)};
  endfunction

  function automatic logic [NUM_SEMA-1:0] lockvec();
    logic [NUM_SEMA-1:0] v;
    v = '0;
    for (int s = 0; s < NUM_SEMA; s++) v[s] = m_lock[s];
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    sif.req_valid = vld;
    sif.ip_flush  = fl;
    for (int i = 0; i < NUM_ON_CHIP_IP; i++)
      for (int t = 0; t < NUM_THREADS; t++)
        sif.req_word[i][t] = wrd[i*NUM_THREADS + t];
  endtask

  // What the hub must do at the coming edge given the inputs now applied.
  task automatic model_edge();
    logic [NUM_REQ-1:0] elig;
    int g, id;
    bit rel;
    if (reset) begin
      for (int s = 0; s < NUM_SEMA; s++) begin m_lock[s] = 0; m_owner[s] = 0; end
      m_mis = 0; m_rr = 0; m_ack = '0; m_ok = '0;
      return;
    end
    for (int s = 0; s < NUM_SEMA; s++)
      if (m_lock[s] && fl[m_owner[s] / NUM_THREADS]) begin m_lock[s] = 0; m_owner[s] = 0; end
    elig = vld & ~m_ack;
    m_ack = '0;
    m_ok  = '0;
    g = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int c;
      c = (m_rr + i) % NUM_REQ;
      if (g < 0 && elig[c]) g = c;
    end
    if (g >= 0) begin
      m_rr = (g + 1) % NUM_REQ;
      m_ack[g] = 1'b1;
      id  = int'(wrd[g][3:0]);
      rel = wrd[g][7];
      if (fl[g / NUM_THREADS]) begin
      end else if (id >= NUM_SEMA) begin
        m_mis = 1;
      end else if (!rel) begin
        if (!m_lock[id]) begin m_lock[id] = 1; m_owner[id] = g; m_ok[g] = 1'b1; end
      end else if (m_lock[id] && m_owner[id] == g) begin
        m_lock[id] = 0; m_owner[id] = 0; m_ok[g] = 1'b1;
      end else begin
        m_mis = 1;
      end
    end
  endtask

  task automatic step();
    drive();
    model_edge();
    @(posedge clk);
    #1;
    chk("ack",    32'(sif.req_ack), 32'(m_ack));
    chk("ok",     32'(sif.req_ok & sif.req_ack), 32'(m_ok));
    chk("locked", 32'(sif.sema_locked), 32'(lockvec()));
    chk("misuse", 32'(sif.misuse_err), 32'(m_mis));
  endtask

  task automatic req_one(int r, bit rel, int id, bit exp_ok, string tag);
    vld[r] = 1'b1;
    wrd[r] = mk(rel, id);
    step();
    chk({tag, " ack"}, 32'(sif.req_ack), 32'(1 << r));
    chk({tag, " ok"},  32'(sif.req_ok[r]), 32'(exp_ok));
    vld[r] = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1;
    vld   = '0;
    fl    = '0;
    for (int r = 0; r < NUM_REQ; r++) wrd[r] = '0;
    step();
    step();
    chk("reset ack",    32'(sif.req_ack), 32'h0);
    chk("reset locked", 32'(sif.sema_locked), 32'h0);
    chk("reset misuse", 32'(sif.misuse_err), 32'h0);
    reset = 1'b0;
    step();

    // basic acquire
    req_one(0, 1'b0, 3, 1'b1, "r0 acq3");
    chk("locked after acq3", 32'(sif.sema_locked), 32'h0008);

    // contention on held sema, then release
    req_one(2, 1'b0, 3, 1'b0, "r2 acq3 held");
    chk("locked unchanged", 32'(sif.sema_locked), 32'h0008);
    req_one(0, 1'b1, 3, 1'b1, "r0 rel3");
    chk("locked after rel3", 32'(sif.sema_locked), 32'h0000);

    // misuse: free release and non-owner release
    req_one(0, 1'b0, 3, 1'b1, "r0 reacq3");
    req_one(1, 1'b1, 5, 1'b0, "r1 rel5 free");
    chk("misuse after free rel", 32'(sif.misuse_err), 32'h1);
    req_one(3, 1'b1, 3, 1'b0, "r3 rel3 nonowner");
    chk("locked after bad rel", 32'(sif.sema_locked), 32'h0008);

    // four-way contention, two rounds, pointer back at r0
    for (int round = 0; round < 2; round++) begin
      for (int r = 0; r < NUM_REQ; r++) begin vld[r] = 1'b1; wrd[r] = mk(1'b0, 7); end
      for (int i = 0; i < NUM_REQ; i++) begin
        step();
        chk($sformatf("rr%0d ack%0d", round, i), 32'(sif.req_ack), 32'(1 << i));
        chk($sformatf("rr%0d ok%0d", round, i), 32'(sif.req_ok[i]),
            32'((round == 0 && i == 0) ? 1 : 0));
        vld[i] = 1'b0;
      end
      step();
    end
    chk("misuse sticky", 32'(sif.misuse_err), 32'h1);
    chk("locked 3,7", 32'(sif.sema_locked), 32'h0088);

    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("misuse cleared", 32'(sif.misuse_err), 32'h0);
    step();

    // flush of IP0 races a release by r1
    req_one(0, 1'b0, 1, 1'b1, "r0 acq1");
    req_one(1, 1'b0, 2, 1'b1, "r1 acq2");
    req_one(2, 1'b0, 4, 1'b1, "r2 acq4");
    chk("locked 1,2,4", 32'(sif.sema_locked), 32'h0016);
    fl     = 2'b01;
    vld[1] = 1'b1;
    wrd[1] = mk(1'b1, 2);
    step();
    chk("flush locked", 32'(sif.sema_locked), 32'h0010);
    chk("flush r1 ack", 32'(sif.req_ack), 32'h2);
    chk("flush r1 ok",  32'(sif.req_ok[1]), 32'h0);
    chk("flush misuse", 32'(sif.misuse_err), 32'h0);
    fl     = 2'b00;
    vld[1] = 1'b0;
    step();

    // reset while a request is pending
    req_one(2, 1'b0, 9, 1'b1, "r2 acq9");
    vld[2] = 1'b1;
    wrd[2] = mk(1'b0, 5);
    reset  = 1'b1;
    step();
    chk("rst drop ack",    32'(sif.req_ack), 32'h0);
    chk("rst drop ok",     32'(sif.req_ok), 32'h0);
    chk("rst drop locked", 32'(sif.sema_locked), 32'h0);
    vld[2] = 1'b0;
    step();
    reset = 1'b0;
    step();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      fl = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (vld[r]) begin
          if (m_ack[r]) begin
            if ($urandom_range(0, 3) != 0) vld[r] = 1'b0;
            else wrd[r] = rand_word();
          end
        end else if ($urandom_range(0, 2) == 0) begin
          vld[r] = 1'b1;
          wrd[r] = rand_word();
        end
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
